// File: rtl/ddr2_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_arbiter
//
// Owns the DDR2 command bus. While the init sequencer runs, its bus is passed
// straight through. Once init_end is seen the bus is shared between a read
// and a write requester (round-robin on simultaneous requests), and a periodic
// auto-refresh (PRE-all, tRP wait, AREF, tRFC wait) is inserted from an
// internal tREFI timer. All bus outputs are registered (1-cycle latency).
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   init_end                    init sequence complete (level)
//   init_cke/cmd/ba/addr        init sequencer bus
//   rd_req, rd_done             read requester request level / release pulse
//   rd_cmd/ba/addr              read requester bus
//   wr_req, wr_done             write requester request level / release pulse
//   wr_cmd/ba/addr              write requester bus
//   rd_grant, wr_grant          requester currently owns the bus
//   ref_pending                 refresh due; owner should finish and release
//   ref_overrun                 sticky: tREFI expired with refresh still pending
//   ddr2_cke/cmd/ba/addr        registered command bus to the PHY
// ---------------------------------------------------------------------------
module ddr2_cmd_arbiter #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int tCK       = 5,
  parameter int tREFI     = 7800,
  parameter int tRP       = 20,
  parameter int tRFC      = 130
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_end,
  input  logic                 init_cke,
  input  logic [3:0]           init_cmd,
  input  logic [BA_BITS-1:0]   init_ba,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 rd_req,
  input  logic                 rd_done,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 wr_req,
  input  logic                 wr_done,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  output logic                 rd_grant,
  output logic                 wr_grant,
  output logic                 ref_pending,
  output logic                 ref_overrun,
  output logic                 ddr2_cke,
  output logic [3:0]           ddr2_cmd,
  output logic [BA_BITS-1:0]   ddr2_ba,
  output logic [ADDR_BITS-1:0] ddr2_addr
);

  localparam int REFI_CYC = tREFI / tCK;
  localparam int RP_CYC   = tRP / tCK;
  localparam int RFC_CYC  = tRFC / tCK;
  localparam int REFI_W   = $clog2(REFI_CYC);
  localparam int PH_MAX   = (RFC_CYC > RP_CYC) ? RFC_CYC : RP_CYC;
  localparam int PH_W     = $clog2(PH_MAX);

  localparam logic [REFI_W-1:0]    REFI_LAST = REFI_W'(REFI_CYC - 1);
  // Wait phases emit RP_CYC-1 / RFC_CYC-1 NOPs, so the phase counter runs 0..CYC-2.
  localparam logic [PH_W-1:0]      RP_LAST   = PH_W'(RP_CYC - 2);
  localparam logic [PH_W-1:0]      RFC_LAST  = PH_W'(RFC_CYC - 2);
  localparam logic [ADDR_BITS-1:0] ADDR_A10  = ADDR_BITS'(1024);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_GNT_RD   = 3'd2;
  localparam logic [2:0] S_GNT_WR   = 3'd3;
  localparam logic [2:0] S_REF_PRE  = 3'd4;
  localparam logic [2:0] S_REF_RP   = 3'd5;
  localparam logic [2:0] S_REF_AREF = 3'd6;
  localparam logic [2:0] S_REF_RFC  = 3'd7;

  logic [2:0]           state, state_nx;
  logic                 last_wr, last_wr_nx;
  logic [PH_W-1:0]      ph_cnt, ph_nx;
  logic [REFI_W-1:0]    refi_cnt;
  logic                 refi_wrap;
  logic                 ref_clr;
  logic                 rd_grant_nx, wr_grant_nx;
  logic                 cke_nx;
  logic [3:0]           cmd_nx;
  logic [BA_BITS-1:0]   ba_nx;
  logic [ADDR_BITS-1:0] addr_nx;

  assign refi_wrap = (state != S_INIT) && (refi_cnt == REFI_LAST);

  always_comb begin
    state_nx    = state;
    last_wr_nx  = last_wr;
    ph_nx       = ph_cnt;
    rd_grant_nx = rd_grant;
    wr_grant_nx = wr_grant;
    ref_clr     = 1'b0;
    cke_nx      = 1'b1;
    cmd_nx      = CMD_NOP;
    ba_nx       = '0;
    addr_nx     = '0;
    case (state)
      S_INIT: begin
        cke_nx  = init_cke;
        cmd_nx  = init_cmd;
        ba_nx   = init_ba;
        addr_nx = init_addr;
        if (init_end) state_nx = S_IDLE;
      end
      S_IDLE: begin
        // Refresh beats any request made in the same decision cycle.
        if (ref_pending) begin
          state_nx = S_REF_PRE;
          ref_clr  = 1'b1;
        end else if ((rd_req && wr_req && last_wr) || (rd_req && !wr_req)) begin
          state_nx    = S_GNT_RD;
          rd_grant_nx = 1'b1;
        end else if (wr_req) begin
          state_nx    = S_GNT_WR;
          wr_grant_nx = 1'b1;
        end
      end
      S_GNT_RD: begin
        cmd_nx     = rd_cmd;
        ba_nx      = rd_ba;
        addr_nx    = rd_addr;
        last_wr_nx = 1'b0;
        if (rd_done) begin
          rd_grant_nx = 1'b0;
          state_nx    = S_IDLE;
        end
      end
      S_GNT_WR: begin
        cmd_nx     = wr_cmd;
        ba_nx      = wr_ba;
        addr_nx    = wr_addr;
        last_wr_nx = 1'b1;
        if (wr_done) begin
          wr_grant_nx = 1'b0;
          state_nx    = S_IDLE;
        end
      end
      S_REF_PRE: begin
        cmd_nx   = CMD_PRE;
        addr_nx  = ADDR_A10;
        ph_nx    = '0;
        state_nx = S_REF_RP;
      end
      S_REF_RP: begin
        if (ph_cnt == RP_LAST) begin
          ph_nx    = '0;
          state_nx = S_REF_AREF;
        end else begin
          ph_nx = ph_cnt + PH_W'(1);
        end
      end
      S_REF_AREF: begin
        cmd_nx   = CMD_AREF;
        ph_nx    = '0;
        state_nx = S_REF_RFC;
      end
      S_REF_RFC: begin
        if (ph_cnt == RFC_LAST) begin
          ph_nx    = '0;
          state_nx = S_IDLE;
        end else begin
          ph_nx = ph_cnt + PH_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      last_wr     <= 1'b1;
      ph_cnt      <= '0;
      refi_cnt    <= '0;
      rd_grant    <= 1'b0;
      wr_grant    <= 1'b0;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
      ddr2_cke    <= 1'b0;
      ddr2_cmd    <= CMD_NOP;
      ddr2_ba     <= '0;
      ddr2_addr   <= '0;
    end else begin
      state     <= state_nx;
      last_wr   <= last_wr_nx;
      ph_cnt    <= ph_nx;
      rd_grant  <= rd_grant_nx;
      wr_grant  <= wr_grant_nx;
      ddr2_cke  <= cke_nx;
      ddr2_cmd  <= cmd_nx;
      ddr2_ba   <= ba_nx;
      ddr2_addr <= addr_nx;
      // Timer is held at zero during init so the first interval starts at init_end.
      if (state == S_INIT || refi_wrap) refi_cnt <= '0;
      else                              refi_cnt <= refi_cnt + REFI_W'(1);
      // A wrap while a refresh is still owed is not queued; it only flags overrun.
      ref_pending <= refi_wrap | (ref_pending & ~ref_clr);
      if (refi_wrap && ref_pending) ref_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr2_cmd_arbiter: directed stimulus, a per-cycle behavioural model of the
// bus owner / refresh timeline, and hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ddr2_cmd_arbiter;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam int REFI = 1560;
  localparam int REF_LEN = 30;   // PRE + 3 NOP + AREF + 25 NOP

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b0;
  logic        init_cke = 1'b0;
  logic [3:0]  init_cmd = NOP;
  logic [2:0]  init_ba = '0;
  logic [13:0] init_addr = '0;
  logic        rd_req = 1'b0, rd_done = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [2:0]  rd_ba = 3'd5;
  logic [13:0] rd_addr = 14'h1234;
  logic        wr_req = 1'b0, wr_done = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [2:0]  wr_ba = 3'd6;
  logic [13:0] wr_addr = 14'h2abc;
  logic        rd_grant, wr_grant, ref_pending, ref_overrun;
  logic        ddr2_cke;
  logic [3:0]  ddr2_cmd;
  logic [2:0]  ddr2_ba;
  logic [13:0] ddr2_addr;

  ddr2_cmd_arbiter dut (
    .clk(clk), .rst(rst), .init_end(init_end), .init_cke(init_cke),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .rd_req(rd_req), .rd_done(rd_done), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .wr_req(wr_req), .wr_done(wr_done), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .rd_grant(rd_grant), .wr_grant(wr_grant), .ref_pending(ref_pending),
    .ref_overrun(ref_overrun), .ddr2_cke(ddr2_cke), .ddr2_cmd(ddr2_cmd),
    .ddr2_ba(ddr2_ba), .ddr2_addr(ddr2_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;
  int pend_rise = -1;
  int ovr_rise  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init;
  int          m_owner;     // 0 none, 1 read, 2 write
  int          m_ref_idx;   // -1 no refresh, else position in refresh command train
  int          m_timer;
  bit          m_pend, m_ovr, m_last_wr;
  logic        e_cke;
  logic [3:0]  e_cmd;
  logic [2:0]  e_ba;
  logic [13:0] e_addr;

  task automatic model_reset();
    m_init = 1; m_owner = 0; m_ref_idx = -1; m_timer = 0;
    m_pend = 0; m_ovr = 0; m_last_wr = 1;
    e_cke = 1'b0; e_cmd = NOP; e_ba = '0; e_addr = '0;
  endtask

  task automatic model_step();
    bit pend_old, clr;
    if (rst) begin model_reset(); return; end
    if (m_init) begin
      e_cke = init_cke; e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr;
      if (init_end) m_init = 0;
      m_timer = 0;
      return;
    end
    pend_old = m_pend; clr = 0;
    e_cke = 1'b1; e_cmd = NOP; e_ba = '0; e_addr = '0;
    if (m_ref_idx >= 0) begin
      if (m_ref_idx == 0) begin e_cmd = PRE; e_addr = 14'h0400; end
      else if (m_ref_idx == 4) e_cmd = AREF;
      m_ref_idx++;
      if (m_ref_idx == REF_LEN) m_ref_idx = -1;
    end else if (m_owner == 1) begin
      e_cmd = rd_cmd; e_ba = rd_ba; e_addr = rd_addr;
      if (rd_done) m_owner = 0;
    end else if (m_owner == 2) begin
      e_cmd = wr_cmd; e_ba = wr_ba; e_addr = wr_addr;
      if (wr_done) m_owner = 0;
    end else begin
      if (pend_old) begin m_ref_idx = 0; clr = 1; end
      else if (rd_req && wr_req) begin
        m_owner = m_last_wr ? 1 : 2; m_last_wr = !m_last_wr;
      end else if (rd_req) begin m_owner = 1; m_last_wr = 0; end
      else if (wr_req) begin m_owner = 2; m_last_wr = 1; end
    end
    if (m_timer == REFI - 1) begin
      m_timer = 0;
      if (pend_old) m_ovr = 1;
      m_pend = 1;
    end else begin
      m_timer++;
      if (clr) m_pend = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [25:0] act, exp;
    logic prev_p, prev_o;
    prev_p = 1'b0; prev_o = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (ref_pending && !prev_p) pend_rise = cyc_no;
      if (ref_overrun && !prev_o) ovr_rise = cyc_no;
      prev_p = ref_pending; prev_o = ref_overrun;
      act = {ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr, rd_grant, wr_grant, ref_pending, ref_overrun};
      exp = {e_cke, e_cmd, e_ba, e_addr, m_owner == 1, m_owner == 2, m_pend, m_ovr};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cyc%0d bus/flags: got %07h expected %07h", cyc_no, act, exp);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic wait_grant(input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_grant) begin got = 1; break; end
      if (wr_grant) begin got = 2; break; end
    end
  endtask

  initial begin
    int e0, got, mism, pre_at, rg_at, found;
    int order[3];

    // Reset state and init pass-through
    repeat (3) @(negedge clk);
    check("rst_cke", 32'(ddr2_cke), 32'd0);
    check("rst_cmd", 32'(ddr2_cmd), 32'(NOP));
    check("rst_grants", 32'({rd_grant, wr_grant}), 32'd0);
    rst = 1'b0;
    init_cke = 1'b1; init_cmd = PRE; init_ba = 3'd3; init_addr = 14'h0400;
    @(negedge clk);
    check("init_pre", 32'(ddr2_cmd), 32'(PRE));
    check("init_ba", 32'(ddr2_ba), 32'd3);
    init_cmd = NOP; init_ba = '0; init_addr = '0;
    @(negedge clk);

    // Round-robin grants with both requesters active
    init_end = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    @(negedge clk);
    e0 = cyc_no;
    for (int k = 0; k < 3; k++) begin
      wait_grant(20, got);
      order[k] = got;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (k == 0) wr_done = (i == 1);   // stray release from the non-owner
      end
      wr_done = 1'b0;
      if (got == 1) rd_done = 1'b1;
      else          wr_done = 1'b1;
      if (k == 2) begin rd_req = 1'b0; wr_req = 1'b0; end
      @(negedge clk);
      rd_done = 1'b0; wr_done = 1'b0;
    end
    check("gnt_order0", 32'(order[0]), 32'd1);
    check("gnt_order1", 32'(order[1]), 32'd2);
    check("gnt_order2", 32'(order[2]), 32'd1);

    // Idle refresh
    repeat (5) @(negedge clk);
    init_end = 1'b0;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ref_pending) begin found = 1; break; end
    end
    check("pend1_seen", 32'(found), 32'd1);
    check("pend1_time", 32'(pend_rise - e0), 32'(REFI));
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ddr2_cmd == PRE) begin found = 1; break; end
    end
    check("ref_pre_found", 32'(found), 32'd1);
    check("ref_a10", 32'(ddr2_addr[10]), 32'd1);
    mism = 0;
    for (int i = 1; i < REF_LEN; i++) begin
      @(negedge clk);
      if (ddr2_cmd !== ((i == 4) ? AREF : NOP)) mism++;
    end
    check("ref_seq", 32'(mism), 32'd0);

    // No preemption of a write grant; refresh runs before the waiting read
    wr_req = 1'b1;
    wait_grant(10, got);
    check("wr_grant", 32'(got), 32'd2);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ref_pending) begin found = 1; break; end
    end
    check("pend2_time", 32'(pend_rise - e0), 32'(2 * REFI));
    rd_req = 1'b1;
    repeat (5) @(negedge clk);
    check("no_preempt", 32'({wr_grant, rd_grant}), 32'b10);
    wr_done = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    wr_done = 1'b0;
    pre_at = -1; rg_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pre_at < 0 && ddr2_cmd == PRE) pre_at = i;
      if (rd_grant) begin rg_at = i; break; end
    end
    check("pre_before_rd", 32'((pre_at >= 0) && (rg_at > pre_at)), 32'd1);
    check("rd_after_ref", 32'(rg_at - pre_at), 32'(REF_LEN));

    // Overrun while a grant is held across two wraps (read keeps the bus)
    found = 0;
    for (int i = 0; i < 3500; i++) begin
      @(negedge clk);
      if (ref_overrun) begin found = 1; break; end
    end
    check("ovr_seen", 32'(found), 32'd1);
    check("ovr_time", 32'(ovr_rise - e0), 32'(4 * REFI));
    repeat (50) @(negedge clk);
    check("ovr_sticky", 32'({ref_overrun, rd_grant}), 32'b11);
    rd_done = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    rd_done = 1'b0;

    // Reset in the middle of tRFC
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ddr2_cmd == AREF) begin found = 1; break; end
    end
    check("aref_before_rst", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_bus", 32'({ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr}),
          32'({1'b0, NOP, 3'd0, 14'd0}));
    check("rst_async_flags", 32'({rd_grant, wr_grant, ref_pending, ref_overrun}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    init_cke = 1'b1; init_cmd = AREF; rd_req = 1'b1;
    @(negedge clk);
    check("init_after_rst", 32'(ddr2_cmd), 32'(AREF));
    check("no_grant_in_init", 32'(rd_grant), 32'd0);
    init_cmd = NOP; rd_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
